// File: rtl/tdc_pair_diff_avg.sv
// TDC pair-difference stage: pairs consecutive measurement words, forms B-A or A+B plus an offset,
// optionally block-averages 2^AVG_LOG2 results, saturates to OUT_W and emits through a delay line.
module tdc_pair_diff_avg #(
  parameter int IN_W     = 37,
  parameter int OUT_W    = 20,
  parameter int OFFSET_A = 30000,
  parameter int OFFSET_B = 30000,
  parameter int AVG_LOG2 = 0,
  parameter int DVAL_DLY = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dval,
  input  logic [IN_W-1:0]  mlt,
  input  logic             first,
  input  logic             sel_b,
  input  logic             mode,
  output logic [OUT_W-1:0] out_data,
  output logic             o_dval,
  output logic             o_sat,
  output logic             o_pair_err
);

  // raw result width: one bit of growth for A+B, one sign bit
  localparam int RW = IN_W + 2;
  localparam int AW = RW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic signed [RW-1:0] OFF_A = RW'(OFFSET_A);
  localparam logic signed [RW-1:0] OFF_B = RW'(OFFSET_B);
  localparam logic [CW-1:0] CNT_MAX = CW'(1 << AVG_LOG2);

  typedef enum logic {IDLE, HAVE_A} state_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } ent_t;

  state_t state, state_n;
  logic cap_a, cap_b, perr;

  logic [IN_W-1:0] a_q, b_q;
  logic            mode_q, sel_q, pd_q;

  logic signed [RW-1:0] a_ext, b_ext, raw_n, raw_q;
  logic                 raw_v, raw_mode;

  logic signed [AW-1:0] acc_q, acc_base, acc_n;
  logic [CW-1:0]        cnt_q, cnt_base, cnt_n;
  logic                 win_mode, restart, done;
  logic signed [RW-1:0] avg;
  logic [OUT_W-1:0]     res_d;
  logic                 res_sat;

  ent_t                dly [DVAL_DLY];
  logic [DVAL_DLY-1:0] vld_pipe;

  // ---------------- pair FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    perr    = 1'b0;
    case (state)
      IDLE: begin
        if (dval) begin
          cap_a   = 1'b1;
          state_n = HAVE_A;
        end
      end
      HAVE_A: begin
        if (dval) begin
          if (first) begin
            cap_a = 1'b1;
            perr  = 1'b1;
          end else begin
            cap_b   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      sel_q      <= 1'b0;
      pd_q       <= 1'b0;
      o_pair_err <= 1'b0;
    end else begin
      if (cap_a) a_q <= mlt;
      if (cap_b) begin
        b_q    <= mlt;
        mode_q <= mode;
        sel_q  <= sel_b;
      end
      pd_q       <= cap_b;
      o_pair_err <= perr;
    end
  end

  // ---------------- stage 1: raw result ----------------
  assign a_ext = $signed({2'b00, a_q});
  assign b_ext = $signed({2'b00, b_q});
  assign raw_n = (mode_q ? (a_ext + b_ext) : (b_ext - a_ext)) + (sel_q ? OFF_B : OFF_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q    <= '0;
      raw_v    <= 1'b0;
      raw_mode <= 1'b0;
    end else begin
      raw_v <= pd_q;
      if (pd_q) begin
        raw_q    <= raw_n;
        raw_mode <= mode_q;
      end
    end
  end

  // ---------------- stage 2: window accumulate, average, saturate ----------------
  // A mode change mid-window throws away the partial sum and starts over with this pair.
  assign restart  = (cnt_q != '0) && (raw_mode != win_mode);
  assign acc_base = restart ? '0 : acc_q;
  assign cnt_base = restart ? '0 : cnt_q;
  assign acc_n    = acc_base + AW'(raw_q);
  assign cnt_n    = cnt_base + CW'(1);
  assign done     = (cnt_n == CNT_MAX);
  // dropping the low AVG_LOG2 bits of a two's-complement sum is a floor division
  assign avg      = acc_n[AW-1:AVG_LOG2];

  always_comb begin
    res_d   = avg[OUT_W-1:0];
    res_sat = 1'b0;
    if (avg[RW-1]) begin
      res_d   = '0;
      res_sat = 1'b1;
    end else if (|avg[RW-2:OUT_W]) begin
      res_d   = '1;
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      win_mode <= 1'b0;
    end else if (raw_v) begin
      win_mode <= raw_mode;
      if (done) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_n;
        cnt_q <= cnt_n;
      end
    end
  end

  // ---------------- delay line (stage 0 doubles as the result register) ----------------
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe << 1) | DVAL_DLY'(raw_v & done);
  end

  always_ff @(posedge clk) begin
    if (raw_v) dly[0] <= '{data: res_d, sat: res_sat};
    for (int i = 1; i < DVAL_DLY; i++) dly[i] <= dly[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      o_sat    <= 1'b0;
      o_dval   <= 1'b0;
    end else begin
      o_dval <= vld_pipe[DVAL_DLY-1];
      if (vld_pipe[DVAL_DLY-1]) begin
        out_data <= dly[DVAL_DLY-1].data;
        o_sat    <= dly[DVAL_DLY-1].sat;
      end
    end
  end

endmodule
